// File: rtl/cnt_ctrl_if.sv
// Command handshake between an upstream sequencer and cnt_ctrl; valid/ready, payload held while ready is low.
interface cnt_ctrl_if #(
  parameter int WIDTH = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/cnt_ctrl.sv
// Counter controller: CLEAR/LOAD take 3 cycles accept-to-accept, RUN N takes N+2; ready only in IDLE, upstream holds the command.
// Optional CNT_CTRL_WRAP_GUARD_EN stops a RUN before cnt_shadow would wrap past all-ones and flags sat.
module cnt_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  cnt_ctrl_if.slave        cmd,
  input  logic             abort,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_shadow,
  output logic             done,
  output logic [WIDTH-1:0] steps,
  output logic             aborted,
  output logic             sat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0]       OP_CLEAR = 2'b00;
  localparam logic [1:0]       OP_LOAD  = 2'b01;
  localparam logic [1:0]       OP_RUN   = 2'b10;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] shadow_inc;

  assign shadow_inc    = cnt_shadow + ONE;

  assign cmd.cmd_ready = (state == S_IDLE);
  assign load          = (state == S_LOAD);
  assign enab          = (state == S_RUN);
  assign done          = (state == S_DONE);

`ifdef CNT_CTRL_WRAP_GUARD_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  logic sat_q;
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt_in     <= '0;
      cnt_shadow <= '0;
      steps      <= '0;
      remaining  <= '0;
      aborted    <= 1'b0;
`ifdef CNT_CTRL_WRAP_GUARD_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              OP_CLEAR: begin
                cnt_in <= '0;
                state  <= S_LOAD;
              end
              OP_LOAD: begin
                cnt_in <= cmd.cmd_data;
                state  <= S_LOAD;
              end
              OP_RUN: begin
                remaining <= cmd.cmd_data;
                steps     <= '0;
                aborted   <= 1'b0;
`ifdef CNT_CTRL_WRAP_GUARD_EN
                sat_q     <= 1'b0;
                // Already at all-ones: any enab would wrap, so refuse the run.
                if (cnt_shadow == ALL_ONES) begin
                  sat_q <= 1'b1;
                  state <= S_DONE;
                end else
`endif
                if (cmd.cmd_data == '0) begin
                  state <= S_DONE;
                end else begin
                  state <= S_RUN;
                end
              end
              default: state <= S_DONE;
            endcase
          end
        end

        S_LOAD: begin
          cnt_shadow <= cnt_in;
          state      <= S_DONE;
        end

        S_RUN: begin
          cnt_shadow <= shadow_inc;
          remaining  <= remaining - ONE;
          steps      <= steps + ONE;
          // Abort is only "early" if more enab cycles were still owed.
          if (abort) begin
            aborted <= (remaining > ONE);
            state   <= S_DONE;
          end
`ifdef CNT_CTRL_WRAP_GUARD_EN
          else if ((shadow_inc == ALL_ONES) && (remaining > ONE)) begin
            sat_q <= 1'b1;
            state <= S_DONE;
          end
`endif
          else if (remaining == ONE) begin
            state <= S_DONE;
          end
        end

        S_DONE: state <= S_IDLE;
      endcase
    end
  end

endmodule
